// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the ROM address, latches the
// ROM word into the IF/ID register and sequences Start / halt / Done.
//
// Control semantics: Start is a level sampled on the rising edge and acted on
// only in IDLE or HALTED. Stall is a level that freezes PC, InstReg, InstValid
// and InstCount for every edge it is high in RUN. BranchEn beats Stall and
// halt detection. InstValid marks the single edge-delayed InstReg word as a
// real (non-flushed) instruction; there is no back-pressure beyond Stall.
module fetch_unit #(
    parameter int          A          = 12,
    parameter int          W          = 9,
    parameter logic [A-1:0] START_ADDR = '0,
    parameter int          CW         = 16
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic          Stall,
    input  logic          BranchEn,
    input  logic          BranchAbs,
    input  logic [A-1:0]  Target,
    input  logic [7:0]    Offset,
    input  logic [W-1:0]  InstIn,
    output logic [A-1:0]  InstAddress,
    output logic [W-1:0]  InstReg,
    output logic          InstValid,
    output logic          Busy,
    output logic          Done,
    output logic [CW-1:0] InstCount,
    output logic [1:0]    DbgState
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_HALTED = 2'd2;

    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [A-1:0]  PC_ONE  = {{(A-1){1'b0}}, 1'b1};

    logic [1:0]    state_q, state_d;
    logic [A-1:0]  pc_q, pc_d;
    logic [W-1:0]  inst_q, inst_d;
    logic          valid_q, valid_d;
    logic [CW-1:0] count_q, count_d;

    logic [A-1:0]  offset_sext;
    logic          halt_word;

    assign offset_sext = {{(A-8){Offset[7]}}, Offset};
    assign halt_word   = (InstIn == {W{1'b1}});

    // Next-state logic: branch > stall > halt > normal fetch while running.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        valid_d = valid_q;
        count_d = count_q;
        case (state_q)
            S_RUN: begin
                if (BranchEn) begin
                    pc_d    = BranchAbs ? Target : pc_q + offset_sext;
                    valid_d = 1'b0;
                end else if (Stall) begin
                    // everything holds
                end else if (halt_word) begin
                    state_d = S_HALTED;
                    valid_d = 1'b0;
                end else begin
                    inst_d  = InstIn;
                    valid_d = 1'b1;
                    pc_d    = pc_q + PC_ONE;
                    count_d = (count_q == CNT_MAX) ? count_q : count_q + CNT_ONE;
                end
            end
            default: begin
                // IDLE and HALTED: wait for Start, nothing valid in flight
                valid_d = 1'b0;
                if (Start) begin
                    state_d = S_RUN;
                    pc_d    = START_ADDR;
                    count_d = '0;
                end
            end
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IDLE;
            pc_q    <= START_ADDR;
            inst_q  <= '0;
            valid_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    assign InstAddress = pc_q;
    assign InstReg     = inst_q;
    assign InstValid   = valid_q;
    assign Busy        = (state_q == S_RUN);
    assign Done        = (state_q == S_HALTED);
    assign InstCount   = count_q;
    assign DbgState    = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, async-reset sequence, then
// randomized run against a cycle-level reference model.
module tb_fetch_unit;
    localparam int A  = 12;
    localparam int W  = 9;
    localparam int CW = 4;

    logic          Clk = 1'b0;
    logic          Reset = 1'b0;
    logic          Start = 1'b0, Stall = 1'b0, BranchEn = 1'b0, BranchAbs = 1'b0;
    logic [A-1:0]  Target = '0;
    logic [7:0]    Offset = '0;
    logic [W-1:0]  InstIn;
    logic [A-1:0]  InstAddress;
    logic [W-1:0]  InstReg;
    logic          InstValid, Busy, Done;
    logic [CW-1:0] InstCount;
    logic [1:0]    DbgState;

    logic [W-1:0]  rom [0:4095];
    assign InstIn = rom[InstAddress];

    fetch_unit #(.A(A), .W(W), .START_ADDR('0), .CW(CW)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Stall(Stall),
        .BranchEn(BranchEn), .BranchAbs(BranchAbs), .Target(Target),
        .Offset(Offset), .InstIn(InstIn), .InstAddress(InstAddress),
        .InstReg(InstReg), .InstValid(InstValid), .Busy(Busy), .Done(Done),
        .InstCount(InstCount), .DbgState(DbgState)
    );

    // clock
    always #5 Clk = ~Clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int addr, input int v, input int r,
                             input int busy, input int done, input int cnt);
        check({tag, " addr"},  32'(InstAddress), 32'(addr));
        check({tag, " valid"}, 32'(InstValid),   32'(v));
        check({tag, " reg"},   32'(InstReg),     32'(r));
        check({tag, " busy"},  32'(Busy),        32'(busy));
        check({tag, " done"},  32'(Done),        32'(done));
        check({tag, " count"}, 32'(InstCount),   32'(cnt));
    endtask

    // drive one cycle: inputs set after a falling edge, sampled at the next one
    task automatic cycle(input logic st, input logic sl, input logic br, input logic ab,
                         input logic [A-1:0] tg, input logic [7:0] of);
        Start = st; Stall = sl; BranchEn = br; BranchAbs = ab; Target = tg; Offset = of;
        @(posedge Clk);
        @(negedge Clk);
    endtask

    // directed vector table
    typedef struct {
        logic          st, sl, br, ab;
        logic [A-1:0]  tg;
        logic [7:0]    of;
        int            e_addr, e_valid, e_reg, e_busy, e_done, e_cnt;
    } vec_t;
    vec_t vecs[$];

    task automatic add(input logic st, input logic sl, input logic br, input logic ab,
                       input logic [A-1:0] tg, input logic [7:0] of,
                       input int ea, input int ev, input int er, input int eb,
                       input int ed, input int ec);
        vec_t v;
        v.st = st; v.sl = sl; v.br = br; v.ab = ab; v.tg = tg; v.of = of;
        v.e_addr = ea; v.e_valid = ev; v.e_reg = er; v.e_busy = eb; v.e_done = ed; v.e_cnt = ec;
        vecs.push_back(v);
    endtask

    // reference model: 0 idle, 1 running, 2 halted
    int m_mode, m_pc, m_reg, m_valid, m_cnt;

    task automatic model_reset();
        m_mode = 0; m_pc = 0; m_reg = 0; m_valid = 0; m_cnt = 0;
    endtask

    task automatic model_step(input logic st, input logic sl, input logic br, input logic ab,
                              input int tg, input int of_signed);
        if (m_mode == 1) begin
            if (br) begin
                m_pc    = ab ? tg : (m_pc + of_signed + 4096) % 4096;
                m_valid = 0;
            end else if (sl) begin
                // frozen
            end else if (int'(rom[m_pc]) == (1 << W) - 1) begin
                m_mode  = 2;
                m_valid = 0;
            end else begin
                m_reg   = int'(rom[m_pc]);
                m_valid = 1;
                m_pc    = (m_pc + 1) % 4096;
                if (m_cnt < (1 << CW) - 1) m_cnt = m_cnt + 1;
            end
        end else if (st) begin
            m_mode = 1; m_pc = 0; m_cnt = 0; m_valid = 0;
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) rom[i] = W'((i * 7 + 3) & 8'hFF);
        rom[0] = 9'h001; rom[1] = 9'h049; rom[2] = 9'h081; rom[3] = 9'h1FF;

        //  st sl br ab  tg      of      addr  v  reg    busy done cnt
        add(1, 0, 0, 0, 12'h0,   8'h00,  'h000, 0, 'h000, 1, 0, 0);
        add(0, 0, 0, 0, 12'h0,   8'h00,  'h001, 1, 'h001, 1, 0, 1);
        add(0, 0, 0, 0, 12'h0,   8'h00,  'h002, 1, 'h049, 1, 0, 2);
        add(0, 0, 0, 0, 12'h0,   8'h00,  'h003, 1, 'h081, 1, 0, 3);
        add(0, 0, 0, 0, 12'h0,   8'h00,  'h003, 0, 'h081, 0, 1, 3);
        add(0, 0, 0, 0, 12'h0,   8'h00,  'h003, 0, 'h081, 0, 1, 3);
        add(1, 0, 0, 0, 12'h0,   8'h00,  'h000, 0, 'h081, 1, 0, 0);
        add(0, 0, 1, 1, 12'h004, 8'h00,  'h004, 0, 'h081, 1, 0, 0);
        add(0, 0, 0, 0, 12'h0,   8'h00,  'h005, 1, 'h01F, 1, 0, 1);
        add(0, 1, 0, 0, 12'h0,   8'h00,  'h005, 1, 'h01F, 1, 0, 1);
        add(0, 1, 0, 0, 12'h0,   8'h00,  'h005, 1, 'h01F, 1, 0, 1);
        add(0, 0, 0, 0, 12'h0,   8'h00,  'h006, 1, 'h026, 1, 0, 2);
        add(0, 0, 0, 0, 12'h0,   8'h00,  'h007, 1, 'h02D, 1, 0, 3);
        add(0, 0, 1, 1, 12'h020, 8'h00,  'h020, 0, 'h02D, 1, 0, 3);
        add(0, 0, 0, 0, 12'h0,   8'h00,  'h021, 1, 'h0E3, 1, 0, 4);
        add(0, 0, 1, 1, 12'h002, 8'h00,  'h002, 0, 'h0E3, 1, 0, 4);
        add(0, 0, 1, 0, 12'h0,   8'hFD,  'hFFF, 0, 'h0E3, 1, 0, 4);
        add(0, 0, 0, 0, 12'h0,   8'h00,  'h000, 1, 'h0FC, 1, 0, 5);
        add(1, 0, 0, 0, 12'h0,   8'h00,  'h001, 1, 'h001, 1, 0, 6);
        add(0, 1, 1, 1, 12'h003, 8'h00,  'h003, 0, 'h001, 1, 0, 6);
        add(0, 1, 1, 0, 12'h0,   8'h02,  'h005, 0, 'h001, 1, 0, 6);
        add(0, 0, 1, 1, 12'h003, 8'h00,  'h003, 0, 'h001, 1, 0, 6);
        add(0, 1, 0, 0, 12'h0,   8'h00,  'h003, 0, 'h001, 1, 0, 6);
        add(0, 0, 0, 0, 12'h0,   8'h00,  'h003, 0, 'h001, 0, 1, 6);

        // reset values
        #12;
        check_all("reset", 0, 0, 0, 0, 0, 0);
        @(negedge Clk);
        Reset = 1'b1;

        foreach (vecs[i]) begin
            cycle(vecs[i].st, vecs[i].sl, vecs[i].br, vecs[i].ab, vecs[i].tg, vecs[i].of);
            check_all($sformatf("vec%0d", i), vecs[i].e_addr, vecs[i].e_valid, vecs[i].e_reg,
                      vecs[i].e_busy, vecs[i].e_done, vecs[i].e_cnt);
        end

        // asynchronous reset between edges while running
        cycle(1, 0, 0, 0, '0, '0);
        cycle(0, 0, 0, 0, '0, '0);
        cycle(0, 0, 0, 0, '0, '0);
        check_all("pre_async", 2, 1, 'h049, 1, 0, 2);
        #2;
        Reset = 1'b0;
        #1;
        check_all("async_rst", 0, 0, 0, 0, 0, 0);
        @(negedge Clk);

        // randomized run against the model
        for (int i = 0; i < 4096; i++)
            rom[i] = ($urandom_range(0, 11) == 0) ? 9'h1FF : W'($urandom_range(0, 510));
        model_reset();
        @(negedge Clk);
        Reset = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            logic st, sl, br, ab;
            logic [A-1:0] tg;
            logic [7:0] of;
            st = ($urandom_range(0, 7) == 0);
            sl = ($urandom_range(0, 3) == 0);
            br = ($urandom_range(0, 5) == 0);
            ab = $urandom_range(0, 1) == 1;
            tg = A'($urandom_range(0, 4095));
            of = 8'($urandom_range(0, 255));
            model_step(st, sl, br, ab, int'(tg), int'($signed(of)));
            cycle(st, sl, br, ab, tg, of);
            check_all($sformatf("rnd%0d", c), m_pc, m_valid, m_reg,
                      (m_mode == 1) ? 1 : 0, (m_mode == 2) ? 1 : 0, m_cnt);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
